// File: rtl/msp430_per_pkg.sv
// Shared types and constants for the MSP430 peripheral-bus initiator.
// The peripheral space size defaults to the global PER_SIZE define.
`ifndef PER_SIZE
`define PER_SIZE 512
`endif

package msp430_per_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] PER_WE_NONE = 2'b00;
  localparam logic [1:0] PER_WE_LO   = 2'b01;
  localparam logic [1:0] PER_WE_HI   = 2'b10;
  localparam logic [1:0] PER_WE_WORD = 2'b11;

  // Bit 15 is never stored: such addresses are rejected before the bus is used.
  typedef struct packed {
    logic [14:0] addr;
    logic        wr;
    logic        bw;
    logic [15:0] wdata;
  } req_t;

  function automatic logic [1:0] lane_we(input logic wr, input logic bw, input logic a0);
    if (!wr)
      return PER_WE_NONE;
    else if (!bw)
      return PER_WE_WORD;
    else
      return a0 ? PER_WE_HI : PER_WE_LO;
  endfunction

endpackage

// File: rtl/msp430_per_initiator_if.sv
// Client request/response channels plus the peripheral bus, bundled together.
// The master modport is the initiator's view; slave is the environment's view.
interface msp430_per_initiator_if;

  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        req_wr;
  logic        req_bw;
  logic [15:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  logic        per_req;
  logic        per_gnt;
  logic        per_en;
  logic [1:0]  per_we;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic [15:0] per_dout;

  modport master (
    input  req_valid, req_addr, req_wr, req_bw, req_wdata,
    input  rsp_ready, per_gnt, per_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output per_req, per_en, per_we, per_addr, per_din
  );

  modport slave (
    output req_valid, req_addr, req_wr, req_bw, req_wdata,
    output rsp_ready, per_gnt, per_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  per_req, per_en, per_we, per_addr, per_din
  );

endinterface

// File: rtl/msp430_per_initiator.sv
// Single-outstanding bus initiator: accepts one client request, waits for the
// backbone grant, runs one peripheral cycle and returns data or an error.
module msp430_per_initiator
  import msp430_per_pkg::*;
#(
  parameter int PER_SIZE = `PER_SIZE,
  parameter int TIMEOUT  = 255,
  parameter int TO_WD    = 8
) (
  input  logic                   mclk,
  input  logic                   puc_rst_n,
  msp430_per_initiator_if.master bus
);

  localparam logic [16:0]      PER_LIMIT = 17'(PER_SIZE);
  localparam logic [TO_WD-1:0] TO_LIMIT  = TO_WD'(TIMEOUT);
  localparam bit               TO_EN     = (TIMEOUT != 0);

  state_t            state;
  state_t            state_nxt;
  req_t              req_q;
  logic [15:0]       rdata_q;
  logic              err_q;
  logic [TO_WD-1:0]  to_cnt;
  logic [TO_WD-1:0]  to_cnt_inc;
  logic              req_bad;
  logic              to_hit;
  logic [15:0]       read_data;

  assign req_bad    = ({1'b0, bus.req_addr} >= PER_LIMIT) ||
                      (!bus.req_bw && bus.req_addr[0]);
  assign to_cnt_inc = to_cnt + TO_WD'(1);
  assign to_hit     = TO_EN && (to_cnt_inc == TO_LIMIT);

  // Byte reads pick the addressed lane and zero-extend it.
  assign read_data = req_q.bw ?
                     {8'h00, req_q.addr[0] ? bus.per_dout[15:8] : bus.per_dout[7:0]} :
                     bus.per_dout;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = req_bad ? RESP : WAIT;
      WAIT:    if (bus.per_gnt)   state_nxt = ACCESS;
               else if (to_hit)   state_nxt = RESP;
      ACCESS:  state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_q   <= '{addr:  bus.req_addr[14:0],
                         wr:    bus.req_wr,
                         bw:    bus.req_bw,
                         wdata: bus.req_wdata};
            err_q   <= req_bad;
            rdata_q <= '0;
            to_cnt  <= '0;
          end
        end
        WAIT: begin
          if (!bus.per_gnt) begin
            to_cnt <= to_cnt_inc;
            if (to_hit) err_q <= 1'b1;
          end
        end
        ACCESS: begin
          rdata_q <= req_q.wr ? 16'h0000 : read_data;
          err_q   <= 1'b0;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // The peripheral bus is OR-combined, so every bus output idles at zero.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 16'h0000;
    bus.rsp_err   = 1'b0;
    bus.per_req   = 1'b0;
    bus.per_en    = 1'b0;
    bus.per_we    = PER_WE_NONE;
    bus.per_addr  = 14'h0000;
    bus.per_din   = 16'h0000;
    case (state)
      IDLE: bus.req_ready = 1'b1;
      WAIT: bus.per_req   = 1'b1;
      ACCESS: begin
        bus.per_req  = 1'b1;
        bus.per_en   = 1'b1;
        bus.per_addr = req_q.addr[14:1];
        bus.per_we   = lane_we(req_q.wr, req_q.bw, req_q.addr[0]);
        if (req_q.wr)
          bus.per_din = req_q.bw ? {req_q.wdata[7:0], req_q.wdata[7:0]} : req_q.wdata;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_msp430_per_initiator.sv
// Scoreboard bench for msp430_per_initiator: expected responses are queued at
// request time and compared when the response handshake completes.
module tb_msp430_per_initiator;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } rsp_t;

  logic        mclk = 1'b0;
  logic        puc_rst_n;
  logic [15:0] periph_data;
  int          n_checks = 0;
  int          n_errors = 0;
  int          en_cnt = 0;
  int          req_cnt = 0;
  logic [13:0] acc_addr = '0;
  logic [1:0]  acc_we = '0;
  logic [15:0] acc_din = '0;
  rsp_t        sb_q[$];

  always #5 mclk = ~mclk;

  msp430_per_initiator_if bus();

  msp430_per_initiator #(.TIMEOUT(4)) dut (
    .mclk      (mclk),
    .puc_rst_n (puc_rst_n),
    .bus       (bus)
  );

  // Peripheral model: drives read data only while it is enabled.
  assign bus.per_dout = bus.per_en ? periph_data : 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bus and response monitor, sampled on the falling edge.
  always @(negedge mclk) begin
    rsp_t exp_rsp;
    if (bus.per_en) begin
      en_cnt++;
      acc_addr = bus.per_addr;
      acc_we   = bus.per_we;
      acc_din  = bus.per_din;
    end else begin
      check("bus_quiet", {bus.per_we, bus.per_addr, bus.per_din}, 32'h0);
    end
    if (bus.per_req) req_cnt++;
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_rsp = sb_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, exp_rsp.rdata);
        check("rsp_err", bus.rsp_err, exp_rsp.err);
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic w, input logic b,
                      input logic [15:0] d, input logic [15:0] er, input logic ee,
                      input bit track);
    int n;
    @(posedge mclk); #1;
    if (track) sb_q.push_back('{rdata: er, err: ee});
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_wr    = w;
    bus.req_bw    = b;
    bus.req_wdata = d;
    n = 0;
    @(negedge mclk);
    while (!bus.req_ready && n < 50) begin
      @(negedge mclk);
      n++;
    end
    check("req_accept", bus.req_ready, 32'd1);
    @(posedge mclk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Counts falling edges until rsp_valid, then steps past the next rising edge.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge mclk);
      lat++;
    end while (!bus.rsp_valid && lat < 50);
    if (!bus.rsp_valid) check("rsp_wait", 32'd0, 32'd1);
    @(posedge mclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int en0;
    int r0;
    puc_rst_n     = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wr    = 1'b0;
    bus.req_bw    = 1'b0;
    bus.req_wdata = 16'h0000;
    bus.rsp_ready = 1'b1;
    bus.per_gnt   = 1'b0;
    periph_data   = 16'h0000;
    #1 puc_rst_n = 1'b0;
    #2;
    check("rst_req_ready", bus.req_ready, 32'd1);
    check("rst_outputs", {bus.rsp_valid, bus.rsp_err, bus.per_req, bus.per_en, bus.rsp_rdata}, 32'h0);
    #9 puc_rst_n = 1'b1;

    // Word read, grant held high: minimum latency.
    bus.per_gnt = 1'b1;
    periph_data = 16'h1234;
    send(16'h0004, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b1);
    wait_rsp(lat);
    check("rd_word_lat", lat, 32'd3);
    check("rd_word_addr", acc_addr, 32'h0002);
    check("rd_word_we", acc_we, 32'h0);
    check("rd_word_din", acc_din, 32'h0);

    // Byte writes to both lanes.
    send(16'h0003, 1'b1, 1'b1, 16'h77A5, 16'h0000, 1'b0, 1'b1);
    wait_rsp(lat);
    check("wr_hi_we", acc_we, 32'h2);
    check("wr_hi_din", acc_din, 32'hA5A5);
    check("wr_hi_addr", acc_addr, 32'h0001);
    send(16'h0002, 1'b1, 1'b1, 16'hFF3C, 16'h0000, 1'b0, 1'b1);
    wait_rsp(lat);
    check("wr_lo_we", acc_we, 32'h1);
    check("wr_lo_din", acc_din, 32'h3C3C);

    // Byte reads from both lanes, then a misaligned word read.
    periph_data = 16'hBEEF;
    send(16'h0001, 1'b0, 1'b1, 16'h0000, 16'h00BE, 1'b0, 1'b1);
    wait_rsp(lat);
    send(16'h0000, 1'b0, 1'b1, 16'h0000, 16'h00EF, 1'b0, 1'b1);
    wait_rsp(lat);
    en0 = en_cnt;
    r0  = req_cnt;
    send(16'h0003, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    wait_rsp(lat);
    check("misalign_lat", lat, 32'd1);
    check("misalign_no_en", en_cnt - en0, 32'd0);
    check("misalign_no_req", req_cnt - r0, 32'd0);

    // Address range boundaries.
    r0 = req_cnt;
    send(16'h0200, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    wait_rsp(lat);
    check("range_lat", lat, 32'd1);
    check("range_no_req", req_cnt - r0, 32'd0);
    send(16'hFFFE, 1'b1, 1'b0, 16'h1111, 16'h0000, 1'b1, 1'b1);
    wait_rsp(lat);
    periph_data = 16'h5500;
    send(16'h01FF, 1'b0, 1'b1, 16'h0000, 16'h0055, 1'b0, 1'b1);
    wait_rsp(lat);
    send(16'h01FE, 1'b1, 1'b0, 16'hBEAD, 16'h0000, 1'b0, 1'b1);
    wait_rsp(lat);
    check("top_word_addr", acc_addr, 32'h00FF);
    check("top_word_din", acc_din, 32'hBEAD);

    // Grant timeout after four WAIT cycles.
    bus.per_gnt = 1'b0;
    en0 = en_cnt;
    r0  = req_cnt;
    send(16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    wait_rsp(lat);
    check("timeout_lat", lat, 32'd5);
    check("timeout_req_cycles", req_cnt - r0, 32'd4);
    check("timeout_no_en", en_cnt - en0, 32'd0);

    // Grant arriving on the third WAIT cycle.
    periph_data = 16'h5A5A;
    en0 = en_cnt;
    send(16'h0020, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 1'b0, 1'b1);
    @(posedge mclk); #1;
    @(posedge mclk); #1;
    bus.per_gnt = 1'b1;
    wait_rsp(lat);
    check("late_gnt_lat", lat, 32'd3);
    check("late_gnt_en", en_cnt - en0, 32'd1);

    // Grant dropping during ACCESS does not abort the access.
    send(16'h0040, 1'b1, 1'b0, 16'hC3C3, 16'h0000, 1'b0, 1'b1);
    @(posedge mclk); #1;
    bus.per_gnt = 1'b0;
    wait_rsp(lat);
    check("gnt_drop_lat", lat, 32'd2);
    check("gnt_drop_we", acc_we, 32'h3);
    check("gnt_drop_din", acc_din, 32'hC3C3);
    check("gnt_drop_addr", acc_addr, 32'h0020);
    bus.per_gnt = 1'b1;

    // Response back-pressure.
    periph_data   = 16'h9876;
    bus.rsp_ready = 1'b0;
    send(16'h0006, 1'b0, 1'b0, 16'h0000, 16'h9876, 1'b0, 1'b1);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge mclk);
      check("hold_valid", bus.rsp_valid, 32'd1);
      check("hold_rdata", bus.rsp_rdata, 32'h9876);
      check("hold_req_ready", bus.req_ready, 32'd0);
    end
    @(posedge mclk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge mclk); #1;
    check("post_rsp_outputs", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'h0);
    check("post_rsp_req_ready", bus.req_ready, 32'd1);

    // Reset while waiting for grant discards the request.
    bus.per_gnt = 1'b0;
    send(16'h0008, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    #2 puc_rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {bus.rsp_valid, bus.rsp_err, bus.per_req, bus.per_en, bus.rsp_rdata}, 32'h0);
    check("mid_rst_req_ready", bus.req_ready, 32'd1);
    @(negedge mclk);
    puc_rst_n = 1'b1;
    repeat (3) begin
      @(negedge mclk);
      check("mid_rst_no_rsp", bus.rsp_valid, 32'd0);
    end
    bus.per_gnt = 1'b1;
    periph_data = 16'h4321;
    send(16'h000A, 1'b0, 1'b0, 16'h0000, 16'h4321, 1'b0, 1'b1);
    wait_rsp(lat);
    check("after_rst_lat", lat, 32'd3);

    repeat (2) @(posedge mclk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
